fast_n_detector: RTL and testbench

Parametrised segment-test corner detector. For each 16-pixel Bresenham ring plus centre it decides whether ARC_LEN contiguous ring pixels are all brighter or all darker than centre by more than a runtime threshold, and computes a corner score. It has a fixed-latency valid pipeline with a global stall and a saturating keypoint counter. It sits between the ring/window buffer and the non-max-suppression / descriptor stages of the VO front end.

---
 rtl/fast_pkg.sv | 25 ++
 rtl/fast_arc_eval.sv | 44 ++++
 rtl/fast_n_detector.sv | 182 ++++++++++++++++++
 tb/tb_fast_n_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// Shared constants, polarity encoding and min/max helpers for the FAST segment-test detector.
package fast_pkg;

  localparam int RING_SIZE    = 16;
  localparam int FAST_LATENCY = 4;
  localparam int MAX_PIX_W    = 16;

  typedef enum logic [1:0] {
    POL_NONE   = 2'b00,
    POL_BRIGHT = 2'b01,
    POL_DARK   = 2'b10
  } fast_pol_e;

  // Callers zero-extend narrower pixels into MAX_PIX_W before use.
  function automatic logic [MAX_PIX_W-1:0] fast_min(input logic [MAX_PIX_W-1:0] a,
                                                    input logic [MAX_PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [MAX_PIX_W-1:0] fast_max(input logic [MAX_PIX_W-1:0] a,
                                                    input logic [MAX_PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fast_arc_eval.sv
// Evaluates one ARC_LEN-long arc starting at ring index START: all-bright, all-dark and min diff.
module fast_arc_eval
  import fast_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9,
  parameter int START   = 0
) (
  input  logic [RING_SIZE-1:0]       bright_i,
  input  logic [RING_SIZE-1:0]       dark_i,
  input  logic [RING_SIZE*PIX_W-1:0] diff_i,
  output logic                       qualify_b_o,
  output logic                       qualify_d_o,
  output logic [PIX_W-1:0]           arcmin_o
);

  logic                 qb_s;
  logic                 qd_s;
  logic [3:0]           idx_s;
  logic [MAX_PIX_W-1:0] min_s;
  logic [MAX_PIX_W-1:0] ext_s;

  // Walk the arc with wrap-around, AND-ing the class bits and tracking the smallest diff.
  always_comb begin
    qb_s  = 1'b1;
    qd_s  = 1'b1;
    idx_s = 4'd0;
    min_s = '1;
    ext_s = '0;
    for (int i = 0; i < ARC_LEN; i++) begin
      idx_s = 4'((START + i) % RING_SIZE);
      qb_s  = qb_s & bright_i[idx_s];
      qd_s  = qd_s & dark_i[idx_s];
      ext_s = '0;
      ext_s[PIX_W-1:0] = diff_i[idx_s*PIX_W +: PIX_W];
      min_s = fast_min(min_s, ext_s);
    end
  end

  assign qualify_b_o = qb_s;
  assign qualify_d_o = qd_s;
  assign arcmin_o    = min_s[PIX_W-1:0];

endmodule

// File: rtl/fast_n_detector.sv
// FAST-N corner detector: 4-stage stallable pipeline (classify, arc eval, group max, output)
// plus a saturating keypoint counter.
module fast_n_detector
  import fast_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9,
  parameter int CNT_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic [RING_SIZE*PIX_W-1:0] i_circle,
  input  logic [PIX_W-1:0]           i_center,
  input  logic [PIX_W-1:0]           i_threshold,
  input  logic                       i_clr_count,
  output logic                       o_valid,
  output logic                       o_flag,
  output logic [1:0]                 o_polarity,
  output logic [PIX_W-1:0]           o_score,
  output logic [CNT_W-1:0]           o_kp_count
);

  if (ARC_LEN < 9 || ARC_LEN > RING_SIZE) begin : g_bad_arc_len
    $error("fast_n_detector: ARC_LEN must lie in 9..16");
  end
  if (PIX_W > MAX_PIX_W) begin : g_bad_pix_w
    $error("fast_n_detector: PIX_W exceeds MAX_PIX_W");
  end

  logic [RING_SIZE*PIX_W-1:0]        diff_d, diff_q;
  logic [RING_SIZE-1:0]              bright_d, bright_q, dark_d, dark_q;
  logic [PIX_W-1:0]                  pix_s, delta_s;
  logic                              v1_q, v2_q, v3_q;
  logic [RING_SIZE-1:0]              qb_s, qd_s, qb_q, qd_q;
  logic [RING_SIZE-1:0][PIX_W-1:0]   arcmin_s, arcmin_q;
  logic [3:0][PIX_W-1:0]             grp_max_d, grp_max_q;
  logic [MAX_PIX_W-1:0]              acc_s, ext_s;
  logic                              flag_d, flag_q;
  fast_pol_e                         pol_d, pol_q;
  logic [PIX_W-1:0]                  score_d;
  logic                              out_valid_q, out_flag_q;
  fast_pol_e                         out_pol_q;
  logic [PIX_W-1:0]                  out_score_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              inc_s;

  // S1 classification: magnitude diff with the bright/dark decision taken on the same subtraction.
  always_comb begin
    diff_d   = '0;
    bright_d = '0;
    dark_d   = '0;
    pix_s    = '0;
    delta_s  = '0;
    for (int k = 0; k < RING_SIZE; k++) begin
      pix_s = i_circle[k*PIX_W +: PIX_W];
      if (i_center >= pix_s) begin
        delta_s   = i_center - pix_s;
        dark_d[k] = (delta_s > i_threshold);
      end else begin
        delta_s     = pix_s - i_center;
        bright_d[k] = (delta_s > i_threshold);
      end
      diff_d[k*PIX_W +: PIX_W] = delta_s;
    end
  end

  for (genvar j = 0; j < RING_SIZE; j++) begin : g_arc
    fast_arc_eval #(
      .PIX_W  (PIX_W),
      .ARC_LEN(ARC_LEN),
      .START  (j)
    ) u_arc (
      .bright_i   (bright_q),
      .dark_i     (dark_q),
      .diff_i     (diff_q),
      .qualify_b_o(qb_s[j]),
      .qualify_d_o(qd_s[j]),
      .arcmin_o   (arcmin_s[j])
    );
  end

  // S3 reduction: non-qualifying arcs contribute 0 to their group maximum.
  always_comb begin
    grp_max_d = '0;
    acc_s     = '0;
    ext_s     = '0;
    for (int g = 0; g < 4; g++) begin
      acc_s = '0;
      for (int a = 0; a < 4; a++) begin
        ext_s = '0;
        if (qb_q[g*4+a] || qd_q[g*4+a]) begin
          ext_s[PIX_W-1:0] = arcmin_q[g*4+a];
        end else begin
          ext_s = '0;
        end
        acc_s = fast_max(acc_s, ext_s);
      end
      grp_max_d[g] = acc_s[PIX_W-1:0];
    end
    flag_d = v2_q && ((|qb_q) || (|qd_q));
    if (!flag_d) begin
      pol_d = POL_NONE;
    end else if (|qb_q) begin
      pol_d = POL_BRIGHT;
    end else begin
      pol_d = POL_DARK;
    end
  end

  // S4 final maximum over the four groups.
  always_comb begin
    score_d = '0;
    for (int g = 0; g < 4; g++) begin
      if (grp_max_q[g] > score_d) begin
        score_d = grp_max_q[g];
      end else begin
        score_d = score_d;
      end
    end
  end

  // Pipeline registers: reset wins over the stall, and the stall freezes every stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      diff_q      <= '0;
      bright_q    <= '0;
      dark_q      <= '0;
      v1_q        <= 1'b0;
      qb_q        <= '0;
      qd_q        <= '0;
      arcmin_q    <= '0;
      v2_q        <= 1'b0;
      grp_max_q   <= '0;
      flag_q      <= 1'b0;
      pol_q       <= POL_NONE;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_flag_q  <= 1'b0;
      out_pol_q   <= POL_NONE;
      out_score_q <= '0;
    end else if (i_en) begin
      diff_q      <= diff_d;
      bright_q    <= bright_d;
      dark_q      <= dark_d;
      v1_q        <= i_valid;
      qb_q        <= qb_s;
      qd_q        <= qd_s;
      arcmin_q    <= arcmin_s;
      v2_q        <= v1_q;
      grp_max_q   <= grp_max_d;
      flag_q      <= flag_d;
      pol_q       <= pol_d;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      out_flag_q  <= v3_q && flag_q;
      out_pol_q   <= (v3_q && flag_q) ? pol_q : POL_NONE;
      out_score_q <= (v3_q && flag_q) ? score_d : '0;
    end
  end

  assign inc_s = i_en && v3_q && flag_q;

  // Keypoint counter: a clear that coincides with a new keypoint leaves exactly that keypoint counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr_count) begin
      cnt_q <= inc_s ? CNT_W'(1) : '0;
    end else if (inc_s && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_valid    = out_valid_q;
  assign o_flag     = out_flag_q;
  assign o_polarity = out_pol_q;
  assign o_score    = out_score_q;
  assign o_kp_count = cnt_q;

endmodule

// File: tb/tb_fast_n_detector.sv
// Scoreboard bench for fast_n_detector: an ARC_LEN=9/CNT_W=4 instance and an ARC_LEN=12 instance.
module tb_fast_n_detector;

  typedef struct {
    logic        flag;
    logic [1:0]  pol;
    logic [7:0]  score;
    logic [15:0] cnt;
    int          adv;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, en, clr, clr12;
  logic         v9, v12;
  logic [127:0] circ9, circ12;
  logic [7:0]   ctr9, thr9, ctr12, thr12;
  logic         ov9, of9, ov12, of12;
  logic [1:0]   op9, op12;
  logic [7:0]   os9, os12;
  logic [3:0]   oc9;
  logic [15:0]  oc12;

  exp_t         q9[$];
  exp_t         q12[$];
  logic [7:0]   pix[16];
  int           checks = 0;
  int           failures = 0;
  int           adv = 0;
  int           cnt9 = 0;
  int           cnt12 = 0;
  logic         en_s, rst_s, clr_s;
  logic [11:0]  prev9;
  logic [3:0]   prevc9;

  always #5 clk = ~clk;

  fast_n_detector #(.PIX_W(8), .ARC_LEN(9), .CNT_W(4)) u_dut9 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(v9), .i_circle(circ9),
    .i_center(ctr9), .i_threshold(thr9), .i_clr_count(clr),
    .o_valid(ov9), .o_flag(of9), .o_polarity(op9), .o_score(os9), .o_kp_count(oc9)
  );

  fast_n_detector #(.PIX_W(8), .ARC_LEN(12), .CNT_W(16)) u_dut12 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(v12), .i_circle(circ12),
    .i_center(ctr12), .i_threshold(thr12), .i_clr_count(clr12),
    .o_valid(ov12), .o_flag(of12), .o_polarity(op12), .o_score(os12), .o_kp_count(oc12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack_ring();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = pix[k];
    return r;
  endfunction

  task automatic fill(input logic [7:0] base);
    for (int k = 0; k < 16; k++) pix[k] = base;
  endtask

  task automatic set_range(input int lo, input int n, input logic [7:0] val);
    for (int i = 0; i < n; i++) pix[(lo + i) % 16] = val;
  endtask

  task automatic drive9(input logic [7:0] c, input logic [7:0] t, input logic ef,
                        input logic [1:0] ep, input logic [7:0] es);
    exp_t e;
    if (ef) cnt9 = (cnt9 == 15) ? 15 : cnt9 + 1;
    e.flag = ef; e.pol = ep; e.score = es; e.cnt = 16'(cnt9); e.adv = adv + 4;
    q9.push_back(e);
    circ9 = pack_ring(); ctr9 = c; thr9 = t; v9 = 1'b1;
    tick();
    v9 = 1'b0;
  endtask

  task automatic drive12(input logic [7:0] c, input logic [7:0] t, input logic ef,
                         input logic [1:0] ep, input logic [7:0] es);
    exp_t e;
    if (ef) cnt12 = cnt12 + 1;
    e.flag = ef; e.pol = ep; e.score = es; e.cnt = 16'(cnt12); e.adv = adv + 4;
    q12.push_back(e);
    circ12 = pack_ring(); ctr12 = c; thr12 = t; v12 = 1'b1;
    tick();
    v12 = 1'b0;
  endtask

  // Monitor: samples on the falling edge; a new output is one loaded by an advancing, non-reset edge.
  task automatic run_monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      en_s = en; rst_s = rst; clr_s = clr;
      if (en && !rst) adv++;
      @(negedge clk);
      if (!rst_s) begin
        if (en_s && ov9 === 1'b1) begin
          if (q9.size() == 0) begin
            check("unexpected_out9", 32'(os9), 32'hFFFF_FFFF);
          end else begin
            e = q9.pop_front();
            check("out9", 32'({of9, op9, os9}), 32'({e.flag, e.pol, e.score}));
            check("cnt9", 32'(oc9), 32'(e.cnt));
            check("lat9", 32'(adv), 32'(e.adv));
          end
        end
        if (en_s && ov12 === 1'b1) begin
          if (q12.size() == 0) begin
            check("unexpected_out12", 32'(os12), 32'hFFFF_FFFF);
          end else begin
            e = q12.pop_front();
            check("out12", 32'({of12, op12, os12}), 32'({e.flag, e.pol, e.score}));
            check("cnt12", 32'(oc12), 32'(e.cnt));
            check("lat12", 32'(adv), 32'(e.adv));
          end
        end
        if (ov9 === 1'b0) check("idle_zero9", 32'({of9, op9, os9}), 32'd0);
        if (!en_s) begin
          check("stall_hold9", 32'({ov9, of9, op9, os9}), 32'(prev9));
          if (!clr_s) check("stall_cnt9", 32'(oc9), 32'(prevc9));
        end
      end
      prev9  = {ov9, of9, op9, os9};
      prevc9 = oc9;
    end
  endtask

  initial begin
    fork
      run_monitor();
    join_none

    rst = 1'b1; en = 1'b1; clr = 1'b0; clr12 = 1'b0;
    v9 = 1'b1; v12 = 1'b1;
    circ9 = {4{$urandom()}}; circ12 = {4{$urandom()}};
    ctr9 = 8'($urandom()); thr9 = 8'd0; ctr12 = 8'($urandom()); thr12 = 8'd0;
    tick();
    circ9 = {4{$urandom()}}; circ12 = {4{$urandom()}};
    tick();
    check("rst_valid9", 32'(ov9), 32'd0);
    check("rst_out9", 32'({of9, op9, os9}), 32'd0);
    check("rst_cnt9", 32'(oc9), 32'd0);
    check("rst_valid12", 32'(ov12), 32'd0);
    rst = 1'b0; v12 = 1'b0;

    fill(8'd100);                                  drive9(8'd100, 8'd20, 1'b0, 2'b00, 8'd0);
    fill(8'd100); set_range(0, 9, 8'd130);         drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd30);
    tick();
    fill(8'd100); set_range(12, 9, 8'd60); pix[2] = 8'd75;
    drive9(8'd100, 8'd20, 1'b1, 2'b10, 8'd25);
    fill(8'd100); set_range(0, 9, 8'd120);         drive9(8'd100, 8'd20, 1'b0, 2'b00, 8'd0);
    fill(8'd100); set_range(0, 9, 8'd121);         drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd21);
    fill(8'd100); set_range(1, 8, 8'd150); pix[0] = 8'd130; pix[9] = 8'd160;
    drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd50);
    fill(8'd250); set_range(0, 9, 8'd0);           drive9(8'd250, 8'd200, 1'b1, 2'b10, 8'd250);

    // 20 back-to-back keypoints with a 3-cycle stall after the tenth; count saturates at 15.
    for (int s = 0; s < 20; s++) begin
      if (s == 10) begin
        en = 1'b0; v9 = 1'b1; circ9 = {4{$urandom()}};
        repeat (3) tick();
        v9 = 1'b0; en = 1'b1;
      end
      fill(8'd100); set_range(0, 9, 8'(111 + s));
      drive9(8'd100, 8'd10, 1'b1, 2'b01, 8'(11 + s));
    end

    // Clear asserted on the very edge that loads this keypoint into the output stage.
    cnt9 = 0;
    fill(8'd100); set_range(4, 9, 8'd140);         drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd40);
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en = 1'b0; clr = 1'b1;
    tick();
    check("clr_while_stalled", 32'(oc9), 32'd0);
    en = 1'b1; clr = 1'b0;
    cnt9 = 0;

    fill(8'd100); set_range(3, 11, 8'd150);        drive12(8'd100, 8'd20, 1'b0, 2'b00, 8'd0);
    fill(8'd100); set_range(3, 12, 8'd150);        drive12(8'd100, 8'd20, 1'b1, 2'b01, 8'd50);
    fill(8'd100); set_range(10, 12, 8'd40);        drive12(8'd100, 8'd20, 1'b1, 2'b10, 8'd60);
    repeat (6) tick();

    // Mid-stream reset discards in-flight keypoints.
    fill(8'd100); set_range(0, 9, 8'd200);         drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd100);
    fill(8'd100); set_range(0, 9, 8'd200);         drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd100);
    rst = 1'b1; v9 = 1'b1;
    tick();
    rst = 1'b0; v9 = 1'b0;
    q9.delete();
    cnt9 = 0;
    check("midrst_valid9", 32'(ov9), 32'd0);
    check("midrst_cnt9", 32'(oc9), 32'd0);
    repeat (6) tick();
    fill(8'd100); set_range(7, 9, 8'd170);         drive9(8'd100, 8'd20, 1'b1, 2'b01, 8'd70);

    for (int i = 0; i < 20 && (q9.size() != 0 || q12.size() != 0); i++) tick();
    check("drain9", 32'(q9.size()), 32'd0);
    check("drain12", 32'(q12.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
